split_stream: RTL and testbench

SPLIT_STREAM -- requirements
Module: split_stream

---
 rtl/split_stream_pkg.sv | 24 ++
 rtl/split_stream_beat_mux.sv | 22 ++
 rtl/split_stream.sv | 131 +++++++++++++
 tb/tb_split_stream.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/split_stream_pkg.sv
// Shared types and helpers for the split_stream tensor-to-head-group splitter.
package split_stream_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of groups to emit: a zero, negative or oversized request means "all groups".
    function automatic logic [31:0] clamp_count(
        input logic        neg,
        input logic [31:0] req,
        input logic [31:0] groups
    );
        logic [31:0] eff;
        if (neg || (req == 32'd0) || (req > groups)) begin
            eff = groups;
        end else begin
            eff = req;
        end
        return eff;
    endfunction

endpackage

// File: rtl/split_stream_beat_mux.sv
// Selects one BEAT_W-wide group slice out of the buffered tensor.
module split_beat_mux #(
    parameter int BEAT_W = 32,
    parameter int GROUPS = 4,
    parameter int CNT_W  = 2
) (
    input  logic [GROUPS*BEAT_W-1:0] buffer,
    input  logic [CNT_W-1:0]         idx,
    output logic [BEAT_W-1:0]        slice
);

    localparam logic [CNT_W:0] GROUPS_LIM = (CNT_W+1)'(GROUPS);

    logic [BEAT_W-1:0] slices_s [GROUPS];

    for (genvar g = 0; g < GROUPS; g++) begin : g_slice
        assign slices_s[g] = buffer[g*BEAT_W +: BEAT_W];
    end

    assign slice = ({1'b0, idx} < GROUPS_LIM) ? slices_s[idx] : '0;

endmodule

// File: rtl/split_stream.sv
// Buffers one input tensor and streams it out as head-group beats with ready/valid handshakes.
module split_stream
    import split_stream_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SEQ_LEN        = 128,
    parameter int HIDDEN         = 768,
    parameter int HEAD_NUM       = 12,
    parameter int HEADS_PER_BEAT = 4,
    parameter int NUM_WIDTH      = 4
) (
    input  logic                                         clk_p,
    input  logic                                         rst_n,
    input  logic [DATA_WIDTH*SEQ_LEN*HIDDEN-1:0]         matrix,
    input  logic [NUM_WIDTH:0]                           num,
    input  logic                                         input_valid_n,
    output logic                                         input_ready,
    output logic [DATA_WIDTH*SEQ_LEN*HEADS_PER_BEAT*(HIDDEN/HEAD_NUM)-1:0] split_matrix,
    output logic [(($clog2(HEAD_NUM/HEADS_PER_BEAT) > 1) ? $clog2(HEAD_NUM/HEADS_PER_BEAT) : 1)-1:0] group_idx,
    output logic                                         output_last,
    output logic                                         output_valid_n,
    input  logic                                         output_ready
);

    localparam int HEAD_DIM = HIDDEN / HEAD_NUM;
    localparam int GROUPS   = HEAD_NUM / HEADS_PER_BEAT;
    localparam int BEAT_W   = DATA_WIDTH * SEQ_LEN * HEADS_PER_BEAT * HEAD_DIM;
    localparam int IN_W     = DATA_WIDTH * SEQ_LEN * HIDDEN;
    localparam int CNT_W    = ($clog2(GROUPS) > 1) ? $clog2(GROUPS) : 1;

    if ((HIDDEN % HEAD_NUM) != 0) begin : g_bad_hidden
        $error("split_stream: HIDDEN must be a multiple of HEAD_NUM");
    end
    if ((HEAD_NUM % HEADS_PER_BEAT) != 0) begin : g_bad_heads
        $error("split_stream: HEAD_NUM must be a multiple of HEADS_PER_BEAT");
    end

    state_t             state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic [CNT_W-1:0]   last_idx_r, last_idx_nx_s;
    logic [IN_W-1:0]    buf_r, buf_nx_s;
    logic [BEAT_W-1:0]  split_r;
    logic [BEAT_W-1:0]  slice_nx_s;
    logic [CNT_W-1:0]   group_idx_r;
    logic               last_r;
    logic               valid_n_r;
    logic               beat_last_s;
    logic               accept_s;
    logic               emit_nx_s;
    logic [31:0]        eff_count_s;

    assign beat_last_s = (state_r == EMIT) && (cnt_r == last_idx_r);
    // Ready in EMIT only while the final beat is being taken, so a new tensor follows with no bubble.
    assign input_ready = (state_r == IDLE) || (beat_last_s && output_ready);
    assign accept_s    = !input_valid_n && input_ready;
    assign eff_count_s = clamp_count(num[NUM_WIDTH], 32'(num[NUM_WIDTH-1:0]), 32'(GROUPS));
    assign emit_nx_s   = (state_nx_s == EMIT);

    // Next-state, counter, count and buffer selection.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        last_idx_nx_s = last_idx_r;
        buf_nx_s      = buf_r;
        if (accept_s) begin
            state_nx_s    = EMIT;
            cnt_nx_s      = '0;
            last_idx_nx_s = CNT_W'(eff_count_s - 32'd1);
            buf_nx_s      = matrix;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s = IDLE;
                end
                EMIT: begin
                    if (output_ready && beat_last_s) begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = '0;
                    end else if (output_ready) begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = '0;
                end
            endcase
        end
    end

    split_beat_mux #(
        .BEAT_W (BEAT_W),
        .GROUPS (GROUPS),
        .CNT_W  (CNT_W)
    ) u_mux (
        .buffer (buf_nx_s),
        .idx    (cnt_nx_s),
        .slice  (slice_nx_s)
    );

    // State, buffer and registered beat outputs, all zeroed outside EMIT.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            last_idx_r  <= CNT_W'(GROUPS - 1);
            buf_r       <= '0;
            split_r     <= '0;
            group_idx_r <= '0;
            last_r      <= 1'b0;
            valid_n_r   <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            last_idx_r  <= last_idx_nx_s;
            buf_r       <= buf_nx_s;
            split_r     <= emit_nx_s ? slice_nx_s : '0;
            group_idx_r <= emit_nx_s ? cnt_nx_s : '0;
            last_r      <= emit_nx_s && (cnt_nx_s == last_idx_nx_s);
            valid_n_r   <= !emit_nx_s;
        end
    end

    assign split_matrix   = split_r;
    assign group_idx      = group_idx_r;
    assign output_last    = last_r;
    assign output_valid_n = valid_n_r;

endmodule

// File: tb/tb_split_stream.sv
// Directed self-checking bench for split_stream with a 4-group, 32-bit-beat configuration.
module tb_split_stream;

    logic         clk_p = 1'b0;
    logic         rst_n;
    logic [127:0] matrix;
    logic [4:0]   num;
    logic         input_valid_n;
    logic         input_ready;
    logic [31:0]  split_matrix;
    logic [1:0]   group_idx;
    logic         output_last;
    logic         output_valid_n;
    logic         output_ready;

    int tests  = 0;
    int failed = 0;

    localparam logic [127:0] M1 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] M2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    logic [31:0] m1_beats [4] = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
    logic [31:0] m2_beats [4] = '{32'h9ABCDEF0, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};

    split_stream #(
        .DATA_WIDTH     (8),
        .SEQ_LEN        (2),
        .HIDDEN         (8),
        .HEAD_NUM       (4),
        .HEADS_PER_BEAT (1),
        .NUM_WIDTH      (4)
    ) dut (
        .clk_p          (clk_p),
        .rst_n          (rst_n),
        .matrix         (matrix),
        .num            (num),
        .input_valid_n  (input_valid_n),
        .input_ready    (input_ready),
        .split_matrix   (split_matrix),
        .group_idx      (group_idx),
        .output_last    (output_last),
        .output_valid_n (output_valid_n),
        .output_ready   (output_ready)
    );

    always #5 clk_p = ~clk_p;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [31:0] data, input logic last);
        chk({tag, "_valid_n"}, 64'(output_valid_n), 64'd0);
        chk({tag, "_idx"}, 64'(group_idx), 64'(idx));
        chk({tag, "_data"}, 64'(split_matrix), 64'(data));
        chk({tag, "_last"}, 64'(output_last), 64'(last));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid_n"}, 64'(output_valid_n), 64'd1);
        chk({tag, "_data"}, 64'(split_matrix), 64'd0);
        chk({tag, "_idx"}, 64'(group_idx), 64'd0);
        chk({tag, "_last"}, 64'(output_last), 64'd0);
        chk({tag, "_ready"}, 64'(input_ready), 64'd1);
    endtask

    // Accept one tensor (we are idle with output_ready high) and drain nbeats beats of M1.
    task automatic run_m1(input string tag, input logic [4:0] n, input int nbeats);
        matrix        = M1;
        num           = n;
        input_valid_n = 1'b0;
        output_ready  = 1'b1;
        chk({tag, "_acc_ready"}, 64'(input_ready), 64'd1);
        tick();
        input_valid_n = 1'b1;
        matrix        = '0;
        num           = '0;
        for (int i = 0; i < nbeats; i++) begin
            chk_beat($sformatf("%s_b%0d", tag, i), i, m1_beats[i], i == nbeats - 1);
            tick();
        end
        chk_idle({tag, "_end"});
    endtask

    initial begin
        rst_n         = 1'b0;
        matrix        = '0;
        num           = '0;
        input_valid_n = 1'b1;
        output_ready  = 1'b0;
        #12;
        chk("rst_valid_n", 64'(output_valid_n), 64'd1);
        chk("rst_data", 64'(split_matrix), 64'd0);
        chk("rst_idx", 64'(group_idx), 64'd0);
        chk("rst_last", 64'(output_last), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("post_rst");

        // Full tensor, then clamped counts
        run_m1("s1", 5'd0, 4);
        run_m1("s2_n2", 5'd2, 2);
        run_m1("s2_n7", 5'd7, 4);
        run_m1("s2_neg", 5'b10000, 4);
        tick();
        chk("s2_idle_hold_valid_n", 64'(output_valid_n), 64'd1);

        // Backpressure on beat 1
        matrix = M1; num = 5'd0; input_valid_n = 1'b0; output_ready = 1'b1;
        tick();
        input_valid_n = 1'b1;
        chk_beat("s3_b0", 0, m1_beats[0], 1'b0);
        tick();
        output_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("s3_hold%0d", i), 1, m1_beats[1], 1'b0);
            tick();
        end
        chk_beat("s3_hold3", 1, m1_beats[1], 1'b0);
        output_ready = 1'b1;
        tick();
        chk_beat("s3_b2", 2, m1_beats[2], 1'b0);
        tick();
        chk_beat("s3_b3", 3, m1_beats[3], 1'b1);
        tick();
        chk_idle("s3_end");

        // Back-to-back tensors with no bubble
        matrix = M1; num = 5'd0; input_valid_n = 1'b0;
        tick();
        input_valid_n = 1'b1;
        tick();
        tick();
        chk_beat("s4_a2", 2, m1_beats[2], 1'b0);
        chk("s4_a2_ready", 64'(input_ready), 64'd0);
        tick();
        chk_beat("s4_a3", 3, m1_beats[3], 1'b1);
        matrix = M2; num = 5'd2; input_valid_n = 1'b0;
        chk("s4_last_ready", 64'(input_ready), 64'd1);
        tick();
        input_valid_n = 1'b1; matrix = '0; num = '0;
        chk_beat("s4_b0", 0, m2_beats[0], 1'b0);
        tick();
        chk_beat("s4_b1", 1, m2_beats[1], 1'b1);
        tick();
        chk_idle("s4_end");

        // New data offered during non-last beats must be ignored
        matrix = M1; num = 5'd0; input_valid_n = 1'b0;
        tick();
        matrix = M2; num = 5'd1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s5_ready%0d", i), 64'(input_ready), 64'd0);
            chk_beat($sformatf("s5_b%0d", i), i, m1_beats[i], 1'b0);
            if (i == 2) input_valid_n = 1'b1;
            tick();
        end
        chk_beat("s5_b3", 3, m1_beats[3], 1'b1);
        tick();
        chk_idle("s5_end");

        // Asynchronous reset during beat 2
        matrix = M1; num = 5'd0; input_valid_n = 1'b0;
        tick();
        input_valid_n = 1'b1;
        tick();
        tick();
        chk_beat("s6_b2", 2, m1_beats[2], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_valid_n", 64'(output_valid_n), 64'd1);
        chk("s6_async_data", 64'(split_matrix), 64'd0);
        chk("s6_async_idx", 64'(group_idx), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("s6_post");
        tick();
        chk_idle("s6_post2");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
